// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: PC width, address type
// and the next-PC source select.
package pc_pkg;

    localparam int PC_W = 8;

    typedef logic [PC_W-1:0] ADDR_T;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_CALL,
        SEL_RET,
        SEL_HOLD
    } sel_e;

    function automatic ADDR_T pc_inc(input ADDR_T a);
        return a + ADDR_T'(1);
    endfunction

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO. Occupancy count is the only state that is reset;
// entry storage is left uninitialised because count alone marks validity.
module pc_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  ADDR_T            push_data,
    output ADDR_T            top,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ADDR_T            mem_q [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             do_push, do_pop;

    // Push and pop are mutually exclusive; push wins if both are raised.
    always_comb begin
        do_push = push && (count_q != CNT_W'(DEPTH));
        do_pop  = !push && pop && (count_q != '0);
        wr_idx  = IDX_W'(count_q);
        rd_idx  = IDX_W'(count_q - CNT_W'(1));
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign top   = mem_q[rd_idx];
    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with branch, call/return and a squash (flush) pulse.
// The return stack is present only when PC_CALL_STACK_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter ADDR_T RESET_PC    = 8'h00,
    parameter int    STACK_DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  branch_take,
    input  ADDR_T branch_target,
    input  logic  call,
    input  logic  ret,
    output ADDR_T pc,
    output logic  flush,
    output logic  stack_full,
    output logic  stack_empty,
    output logic  stack_err
);

    ADDR_T pc_q, pc_d, pc_next_seq, top;
    logic  flush_q, flush_d;
    logic  err_q, err_d, err_set;
    logic  full, empty;
    sel_e  sel;

    assign pc_next_seq = pc_inc(pc_q);

`ifdef PC_CALL_STACK_EN
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [CNT_W-1:0] count;
    logic             push, pop;

    // A call on a full stack still jumps; only the push is dropped.
    assign push = (sel == SEL_CALL) && !full;
    assign pop  = (sel == SEL_RET);

    pc_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .push_data(pc_next_seq),
        .top      (top),
        .count    (count)
    );

    assign full  = (count == CNT_W'(STACK_DEPTH));
    assign empty = (count == '0);
`else
    logic unused_ok;

    assign unused_ok = ^{call, ret, 1'(STACK_DEPTH)};
    assign top       = '0;
    assign full      = 1'b0;
    assign empty     = 1'b1;
`endif

    // Priority: hold, illegal call&ret, ret, call, branch, sequential.
    always_comb begin
        sel     = SEL_SEQ;
        err_set = 1'b0;
        if (!en) begin
            sel = SEL_HOLD;
        end
`ifdef PC_CALL_STACK_EN
        else if (call && ret) begin
            err_set = 1'b1;
        end else if (ret) begin
            if (empty) begin
                err_set = 1'b1;
            end else begin
                sel = SEL_RET;
            end
        end else if (call) begin
            sel     = SEL_CALL;
            err_set = full;
        end
`endif
        else if (branch_take) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_SEQ:    pc_d = pc_next_seq;
            SEL_BRANCH: pc_d = branch_target;
            SEL_CALL:   pc_d = branch_target;
            SEL_RET:    pc_d = top;
            SEL_HOLD:   pc_d = pc_q;
            default:    pc_d = pc_q;
        endcase
        flush_d = (sel == SEL_BRANCH) || (sel == SEL_CALL) || (sel == SEL_RET);
        err_d   = err_q | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign pc          = pc_q;
    assign flush       = flush_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_pc_sequencer;

    localparam logic [7:0] RST_PC = 8'h00;
    localparam int         DEPTH  = 8;
`ifdef PC_CALL_STACK_EN
    localparam bit HAS_STK = 1'b1;
`else
    localparam bit HAS_STK = 1'b0;
`endif

    logic       clk, rst_n, en, branch_take, call, ret;
    logic [7:0] branch_target;
    logic [7:0] pc;
    logic       flush, stack_full, stack_empty, stack_err;

    pc_sequencer #(
        .RESET_PC   (RST_PC),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .branch_take  (branch_take),
        .branch_target(branch_target),
        .call         (call),
        .ret          (ret),
        .pc           (pc),
        .flush        (flush),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_pc;
    logic       m_flush, m_err;
    logic [7:0] m_stk[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       bt;
        logic [7:0] tgt;
        logic [7:0] exp_pc;
        logic       exp_flush;
    } vec_t;

    vec_t tbl[12];

    task automatic model_reset();
        m_pc    = RST_PC;
        m_flush = 1'b0;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic e, input logic b, input logic [7:0] t,
                              input logic c, input logic r);
        m_flush = 1'b0;
        if (!e) return;
        if (HAS_STK && c && r) begin
            m_pc  = m_pc + 8'd1;
            m_err = 1'b1;
        end else if (HAS_STK && r) begin
            if (m_stk.size() > 0) begin
                m_pc    = m_stk.pop_back();
                m_flush = 1'b1;
            end else begin
                m_pc  = m_pc + 8'd1;
                m_err = 1'b1;
            end
        end else if (HAS_STK && c) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 8'd1);
            else m_err = 1'b1;
            m_pc    = t;
            m_flush = 1'b1;
        end else if (b) begin
            m_pc    = t;
            m_flush = 1'b1;
        end else begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},    pc,                   m_pc);
        check({tag, ".flush"}, {7'd0, flush},        {7'd0, m_flush});
        check({tag, ".full"},  {7'd0, stack_full},   {7'd0, m_stk.size() == DEPTH});
        check({tag, ".empty"}, {7'd0, stack_empty},  {7'd0, m_stk.size() == 0});
        check({tag, ".err"},   {7'd0, stack_err},    {7'd0, m_err});
    endtask

    task automatic step(input string tag, input logic e, input logic b,
                        input logic [7:0] t, input logic c, input logic r);
        @(negedge clk);
        en            = e;
        branch_take   = b;
        branch_target = t;
        call          = c;
        ret           = r;
        @(posedge clk);
        model_step(e, b, t, c, r);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; branch_take = 1'b0; call = 1'b0; ret = 1'b0; branch_target = 8'h00;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 8'h01, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 8'h02, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'h03, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 8'h10, 8'h10, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 8'h40, 8'h40, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 8'h40, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h99, 8'h40, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 8'h01, 8'h01, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'h55, 8'h01, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'h00, 8'h02, 1'b0};

        rst_n = 1'b0;
        en = 1'b0; branch_take = 1'b0; call = 1'b0; ret = 1'b0; branch_target = 8'h00;
        model_reset();
        #12;
        check_all("por");
        rst_n = 1'b1;

        // Vector table: sequential start, branch, hold, wrap, target == pc+1
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].bt, tbl[i].tgt, 1'b0, 1'b0);
            check($sformatf("tbl%0d.exp_pc", i), pc, tbl[i].exp_pc);
            check($sformatf("tbl%0d.exp_flush", i), {7'd0, flush}, {7'd0, tbl[i].exp_flush});
        end

        // Call then immediate return
        do_reset();
        step("goto20", 1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        step("call80", 1'b1, 1'b0, 8'h80, 1'b1, 1'b0);
        check("call80.fixed", pc, HAS_STK ? 8'h80 : 8'h21);
        step("ret21", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ret21.fixed", pc, HAS_STK ? 8'h21 : 8'h22);
        check("ret21.empty", {7'd0, stack_empty}, 8'h01);

        // Overfill the stack then unwind it
        do_reset();
        for (int i = 0; i <= DEPTH; i++) begin
            step($sformatf("deep_call%0d", i), 1'b1, 1'b0, 8'(8'h10 * (i + 1) + 3), 1'b1, 1'b0);
        end
        check("deep.err", {7'd0, stack_err}, {7'd0, HAS_STK});
        check("deep.full", {7'd0, stack_full}, {7'd0, HAS_STK});
        for (int i = 0; i < DEPTH; i++) begin
            step($sformatf("deep_ret%0d", i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        end
        check("unwind.empty", {7'd0, stack_empty}, 8'h01);

        // Return on empty stack and the illegal call&ret combination
        do_reset();
        step("goto05", 1'b1, 1'b1, 8'h05, 1'b0, 1'b0);
        step("ret_empty", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ret_empty.pc", pc, 8'h06);
        check("ret_empty.err", {7'd0, stack_err}, {7'd0, HAS_STK});
        step("call_ret", 1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
        check("call_ret.pc", pc, 8'h07);
        check("call_ret.flush", {7'd0, flush}, 8'h00);
        step("err_sticky", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset asserted mid-cycle discards the in-flight branch
        @(negedge clk);
        en = 1'b1; branch_take = 1'b1; branch_target = 8'h77; call = 1'b0; ret = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        branch_take = 1'b0;
        @(posedge clk);
        model_step(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        #1;
        check_all("post_rst");
        check("post_rst.fixed", pc, RST_PC + 8'd1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 3) == 0,
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
